// File: rtl/seg7_points_decoder.sv
// Readback decoder for the two-digit active-low 7-segment score word.
// Waits for a stable new word, decodes it to 0..30 and offers it once through valid/ready.
module seg7_points_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] seg_q,
    output logic [6:0]  points,
    output logic        err,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned SEG_W = 14;
    localparam int unsigned DIG_W = 7;
    localparam int unsigned PTS_W = 7;
    localparam int unsigned CNT_W = 16;

    localparam logic [SEG_W-1:0] PAT_00   = 14'b1000000_1000000;
    localparam logic [PTS_W-1:0] PTS_ERR  = 7'h7F;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DECODE, HOLD} state_t;

    state_t           state;
    logic [SEG_W-1:0] seg_r;
    logic [SEG_W-1:0] cap;
    logic [SEG_W-1:0] last_pat;
    logic [CNT_W-1:0] cnt;

    logic [4:0]       tens_c;
    logic [4:0]       units_c;
    logic             illegal_c;
    logic [PTS_W-1:0] sum_c;

    // Returns {legal, value}; anything outside the ten standard glyphs is illegal.
    function automatic logic [4:0] digit_decode(input logic [DIG_W-1:0] s);
        case (s)
            7'b1000000: return {1'b1, 4'd0};
            7'b1111001: return {1'b1, 4'd1};
            7'b0100100: return {1'b1, 4'd2};
            7'b0110000: return {1'b1, 4'd3};
            7'b0011001: return {1'b1, 4'd4};
            7'b0010010: return {1'b1, 4'd5};
            7'b0000010: return {1'b1, 4'd6};
            7'b1111000: return {1'b1, 4'd7};
            7'b0000000: return {1'b1, 4'd8};
            7'b0010000: return {1'b1, 4'd9};
            default:    return 5'd0;
        endcase
    endfunction

    // Decode of the captured word; 31..39 are outside the encoder range.
    always_comb begin
        tens_c    = digit_decode(cap[13:7]);
        units_c   = digit_decode(cap[6:0]);
        illegal_c = 1'b0;
        if (!tens_c[4] || !units_c[4] || (tens_c[3:0] > 4'd3) ||
            ((tens_c[3:0] == 4'd3) && (units_c[3:0] != 4'd0))) begin
            illegal_c = 1'b1;
        end
        sum_c = PTS_W'(tens_c[3:0]) * PTS_W'(10) + PTS_W'(units_c[3:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seg_r     <= PAT_00;
            cap       <= PAT_00;
            last_pat  <= PAT_00;
            cnt       <= '0;
            points    <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            seg_r <= seg_q;
            unique case (state)
                IDLE: begin
                    if (seg_r != last_pat) begin
                        cap   <= seg_r;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (seg_r != cap) begin
                        cap <= seg_r;
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DECODE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DECODE: begin
                    points    <= illegal_c ? PTS_ERR : sum_c;
                    err       <= illegal_c;
                    last_pat  <= cap;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
